// File: rtl/button_debounce.sv
// Push-button debouncer: 2-flop synchronizer, four-state debounce FSM, registered clean level and edge strobes.
// Optional long-press strobe enabled by defining BUTTON_DEBOUNCE_LONG_PRESS_EN.
module button_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES   = 500000,
   parameter int unsigned LONG_PRESS_CYCLES = 50000000
) (
   input  logic Clk,
   input  logic Reset,
   input  logic button_raw,
   output logic button_clean,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_press
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE_LOW,
      WAIT_HIGH,
      STABLE_HIGH,
      WAIT_LOW
   } state_e;

   logic            sync1_q, sync2_q;
   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            clean_q, press_q, release_q;
   logic            cleanNext;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= button_raw;
         sync2_q <= sync1_q;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE_LOW;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // The counter stops at DEBOUNCE_CYCLES-1, so it can never wrap.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE_LOW: begin
            if (sync2_q) begin
               state_d = WAIT_HIGH;
               cnt_d   = '0;
            end
         end
         WAIT_HIGH: begin
            if (!sync2_q) begin
               state_d = IDLE_LOW;
            end else if (cnt_q == LastCnt) begin
               state_d = STABLE_HIGH;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         STABLE_HIGH: begin
            if (!sync2_q) begin
               state_d = WAIT_LOW;
               cnt_d   = '0;
            end
         end
         WAIT_LOW: begin
            if (sync2_q) begin
               state_d = STABLE_HIGH;
            end else if (cnt_q == LastCnt) begin
               state_d = IDLE_LOW;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: begin
            state_d = IDLE_LOW;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      cleanNext = (state_q == STABLE_HIGH) || (state_q == WAIT_LOW);
   end

   // Strobes are derived from the clean level changing, so a WAIT_LOW bounce back produces none.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         clean_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         clean_q   <= cleanNext;
         press_q   <= cleanNext & ~clean_q;
         release_q <= ~cleanNext & clean_q;
      end
   end

   assign button_clean  = clean_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
   localparam int unsigned HoldW = $clog2(LONG_PRESS_CYCLES + 2);
   localparam logic [HoldW-1:0] HoldFire = HoldW'(LONG_PRESS_CYCLES);
   localparam logic [HoldW-1:0] HoldSat  = HoldW'(LONG_PRESS_CYCLES + 1);

   logic [HoldW-1:0] hold_q, hold_d;
   logic             long_q, longFire;

   // Saturating one past the fire value guarantees a single strobe per press.
   always_comb begin
      hold_d = hold_q;
      if ((state_d == STABLE_HIGH) && (state_q != STABLE_HIGH)) begin
         hold_d = '0;
      end else if ((state_q == STABLE_HIGH) && (hold_q != HoldSat)) begin
         hold_d = hold_q + HoldW'(1);
      end
      longFire = (state_q == STABLE_HIGH) && (hold_q == HoldFire);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         hold_q <= '0;
         long_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         long_q <= longFire;
      end
   end

   assign long_press = long_q;
`else
   assign long_press = 1'b0;
`endif

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning the number of consecutive stable cycles required to accept a level change (10 ms at 50 MHz); legal range >= 1.
REQ-002 SHALL have parameter LONG_PRESS_CYCLES, default 50000000, meaning the number of held cycles in the accepted-high state before long_press fires; legal range >= 1.
REQ-003 SHALL have port Clk  input  1  the single system clock; all state is updated on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port button_raw  input  1  the asynchronous, bouncing push-button level (1 = pressed).
REQ-006 SHALL have port button_clean  output  1  the debounced level, suitable to drive the downstream function-select FSM button input.
REQ-007 SHALL have port press_pulse  output  1  a one-cycle strobe on each accepted 0->1 change.
REQ-008 SHALL have port release_pulse  output  1  a one-cycle strobe on each accepted 1->0 change.
REQ-009 SHALL have port long_press  output  1  a one-cycle strobe when a press is held for LONG_PRESS_CYCLES cycles.

Function
REQ-010 SHALL pass button_raw through a 2-flop synchronizer; only the second flop output (sync) feeds the logic.
REQ-011 SHALL implement the states IDLE_LOW, WAIT_HIGH, STABLE_HIGH and WAIT_LOW.
REQ-012 In IDLE_LOW: sync=1 -> WAIT_HIGH, with the debounce counter cleared to 0.
REQ-013 In WAIT_HIGH: sync=0 -> IDLE_LOW (bounce rejected, no pulse); else increment the counter; when counter == DEBOUNCE_CYCLES-1 and sync=1 -> STABLE_HIGH.
REQ-014 In STABLE_HIGH: sync=0 -> WAIT_LOW, with the counter cleared to 0.
REQ-015 In WAIT_LOW: sync=1 -> STABLE_HIGH (no pulse); else increment the counter; when counter == DEBOUNCE_CYCLES-1 and sync=0 -> IDLE_LOW.
REQ-016 button_clean SHALL be 1 exactly in STABLE_HIGH and WAIT_LOW, and registered (no combinational path from button_raw).
REQ-017 Latency: for a clean step on button_raw, button_clean SHALL change on edge E0+DEBOUNCE_CYCLES+3, where E0 is the edge that first samples the new level.
REQ-018 press_pulse SHALL be high only in the first cycle button_clean is 1 after an IDLE_LOW path, and release_pulse only in the first cycle button_clean is 0 after a WAIT_LOW path; the two pulses are never high simultaneously.
REQ-019 The debounce counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide and SHALL never wrap.
REQ-020 Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no change on any output.

Reset
REQ-021 Reset=1 SHALL immediately force the following values: synchronizer flops 0, state IDLE_LOW, all counters 0, and button_clean, press_pulse, release_pulse and long_press 0.
REQ-022 Reset asserted mid-debounce or mid-hold SHALL discard progress; a button held through reset release SHALL produce a normal press_pulse after REQ-017 latency.

Configuration
REQ-023 Macro BUTTON_DEBOUNCE_LONG_PRESS_EN SHALL control long-press detection.
REQ-024 With the macro defined: a hold counter clears on STABLE_HIGH entry and increments while in STABLE_HIGH; long_press pulses for one cycle on the LONG_PRESS_CYCLES-th edge after STABLE_HIGH entry; the counter then saturates, giving at most one long_press per press; leaving STABLE_HIGH (including a WAIT_LOW bounce back) restarts the count.
REQ-025 With the macro undefined: long_press SHALL be tied to 0, no hold counter logic is generated, and the port list is unchanged.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, macro defined unless noted)
REQ-026 Clean press at E0 -> button_clean=1 and press_pulse=1 for one cycle at E0+7; release at E1 -> button_clean=0 and release_pulse=1 at E1+7.
REQ-027 Raw high for 3 cycles then low -> all outputs stay 0; raw high, low for 1 cycle, then high held -> press_pulse exactly once, 7 edges after the final rise.
REQ-028 Press held 30 cycles -> long_press=1 for exactly one cycle, 10 edges after button_clean rises; no repeat.
REQ-029 Reset asserted 2 cycles into WAIT_HIGH, button still held -> outputs 0 immediately; after Reset=0, press_pulse 7 edges after the first sampling edge.
REQ-030 Macro undefined, press held 30 cycles -> long_press stays 0, while press_pulse and button_clean behave as in REQ-026.
